// File: rtl/decoder_pkg.sv
// Shared types and defaults for the decoder access arbiter.
package decoder_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CODE_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Increment an index and wrap it back to zero at n.
   function automatic int wrap_inc(input int idx, input int n);
      int nxt;
      if ((idx + 32'sd1) >= n) begin
         nxt = 32'sd0;
      end else begin
         nxt = idx + 32'sd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/decoder_access_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_priority_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         winner_oh_o,
   output logic [$clog2(NUM_REQ)-1:0] winner_idx_o,
   output logic                       any_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] cand_s;
   logic             found_s;

   // Scan requests starting at the pointer; the first hit is the winner.
   always_comb begin
      winner_oh_o  = '0;
      winner_idx_o = '0;
      found_s      = 1'b0;
      cand_s       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = IDX_W'((32'(ptr_i) + 32'(i)) % 32'(NUM_REQ));
         if (!found_s && req_i[cand_s]) begin
            found_s              = 1'b1;
            winner_idx_o         = cand_s;
            winner_oh_o[cand_s]  = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/decoder_access_arbiter.sv
// Shares one decoder between NUM_REQ requesters with round-robin grants,
// a single-cycle decode start, and a watchdog that aborts hung decodes.
module decoder_access_arbiter
   import decoder_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CODE_WIDTH     = DEF_CODE_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*CODE_WIDTH-1:0] req_code,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_error,
   output logic                          busy,
   output logic                          dec_start,
   output logic [CODE_WIDTH-1:0]         dec_code,
   input  logic                          dec_data_ready,
   input  logic [DATA_WIDTH-1:0]         dec_out_value
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   arb_state_t              state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic [WD_W-1:0]         wdog_q, wdog_d;
   logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
   logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    resp_error_q, resp_error_d;
   logic                    busy_q, busy_d;
   logic                    dec_start_q, dec_start_d;
   logic [CODE_WIDTH-1:0]   dec_code_q, dec_code_d;

   logic [NUM_REQ-1:0]      win_oh_s;
   logic [IDX_W-1:0]        win_idx_s;
   logic                    win_any_s;
   logic                    ready_ok_s;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i        (req),
      .ptr_i        (ptr_q),
      .winner_oh_o  (win_oh_s),
      .winner_idx_o (win_idx_s),
      .any_o        (win_any_s)
   );

   // The decoder has no reset, so its ready line may be stale or X while
   // dec_start is high; only a ready seen after the start cycle counts.
   assign ready_ok_s = (dec_data_ready == 1'b1) && !dec_start_q && (wdog_q < WD_LIMIT);

   // Next-state and registered-output computation for the arbitration FSM.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      wdog_d       = wdog_q;
      req_ack_d    = '0;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      dec_start_d  = 1'b0;
      dec_code_d   = dec_code_q;

      case (state_q)
         IDLE: begin
            if (win_any_s) begin
               req_ack_d   = win_oh_s;
               dec_start_d = 1'b1;
               dec_code_d  = req_code[win_idx_s*CODE_WIDTH +: CODE_WIDTH];
               grant_d     = win_idx_s;
               ptr_d       = IDX_W'(wrap_inc(32'(win_idx_s), NUM_REQ));
               wdog_d      = '0;
               state_d     = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            wdog_d = wdog_q + WD_W'(1);
            // Ready is checked first so it wins over a same-cycle timeout.
            if (ready_ok_s) begin
               resp_data_d           = dec_out_value;
               resp_error_d          = 1'b0;
               resp_valid_d[grant_q] = 1'b1;
               state_d               = RESP;
            end else if (wdog_q == WD_LAST) begin
               resp_data_d           = '0;
               resp_error_d          = 1'b1;
               resp_valid_d[grant_q] = 1'b1;
               state_d               = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         wdog_q       <= '0;
         req_ack_q    <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
         busy_q       <= 1'b0;
         dec_start_q  <= 1'b0;
         dec_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         wdog_q       <= wdog_d;
         req_ack_q    <= req_ack_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         busy_q       <= busy_d;
         dec_start_q  <= dec_start_d;
         dec_code_q   <= dec_code_d;
      end
   end

   assign req_ack    = req_ack_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;
   assign busy       = busy_q;
   assign dec_start  = dec_start_q;
   assign dec_code   = dec_code_q;

endmodule
